run_controller: RTL and testbench

Hardware run sequencer for the `singlecycle` core. It drives the core's `resetl`/`startpc` inputs, waits for `currentpc` to reach a list of programmed checkpoint addresses, and samples `dmemout` one cycle later to compare against an expected pass code. It also runs a global watchdog. It sits between a host/config port and the core, and replaces bench-driven program sequencing on FPGA bring-up.

---
 rtl/run_ctrl_pkg.sv | 22 ++
 rtl/chk_table.sv | 42 ++++
 rtl/run_controller.sv | 188 ++++++++++++++++++
 tb/tb_run_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types for the run sequencer: FSM state encoding and checkpoint record.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    RC_IDLE,
    RC_RESET_CORE,
    RC_RUN,
    RC_SETTLE,
    RC_CHECK,
    RC_DONE
  } rc_state_t;

  // "expect" is a reserved word, so the expected data field is named "expected".
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] expected;
  } chk_entry_t;

  localparam int         WD_W     = 16;
  localparam logic [7:0] PASS_SAT = 8'hFF;

endpackage

// File: rtl/chk_table.sv
// Checkpoint register file: entries are appended in order and read back by index.
module chk_table
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CHK = 4
) (
  input  logic                       CLK,
  input  logic                       resetl,
  input  logic                       clear,
  input  logic                       wr_en,
  input  chk_entry_t                 wr_data,
  input  logic [$clog2(NUM_CHK)-1:0] rd_idx,
  output chk_entry_t                 rd_data,
  output logic [$clog2(NUM_CHK):0]   entries,
  output logic                       full
);

  localparam int IW = $clog2(NUM_CHK);

  chk_entry_t    mem [NUM_CHK];
  logic [IW:0]   count_reg;

  assign full    = (count_reg == (IW+1)'(NUM_CHK));
  assign entries = count_reg;
  assign rd_data = mem[rd_idx];

  always_ff @(posedge CLK) begin
    if (!resetl || clear) begin
      count_reg <= '0;
    end else if (wr_en && !full) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Storage is not reset; the count alone defines which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_en && !full) begin
      mem[count_reg[IW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run sequencer for the singlecycle core: resets the core, waits on checkpoint
// PCs, compares the loaded data against expected codes, and enforces a watchdog.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CHK         = 4,
  parameter int CORE_RST_CYCLES = 1,
  parameter int WATCHDOG_MAX    = 255
) (
  input  logic                       CLK,
  input  logic                       resetl,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [63:0]                cfg_pc,
  input  logic [63:0]                cfg_expect,
  input  logic                       cfg_clear,
  input  logic                       go,
  input  logic [63:0]                startpc,
  output logic                       core_resetl,
  output logic [63:0]                core_startpc,
  input  logic [63:0]                currentpc,
  input  logic [63:0]                dmemout,
  output logic                       busy,
  output logic                       done,
  output logic                       all_passed,
  output logic [7:0]                 pass_count,
  output logic                       fail,
  output logic [$clog2(NUM_CHK)-1:0] fail_index,
  output logic [63:0]                fail_value,
  output logic                       watchdog_expired
);

  localparam int              IW       = $clog2(NUM_CHK);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_MAX);
  localparam logic [15:0]     RST_LAST = 16'(CORE_RST_CYCLES - 1);

  rc_state_t        state_reg, state_next;
  logic [15:0]      rst_cnt_reg, rst_cnt_next;
  logic [WD_W-1:0]  wd_reg, wd_next;
  logic [IW:0]      idx_reg, idx_next;
  logic             core_resetl_reg, core_resetl_next;
  logic [63:0]      core_startpc_reg, core_startpc_next;
  logic [7:0]       pass_count_reg, pass_count_next;
  logic             fail_reg, fail_next;
  logic [IW-1:0]    fail_index_reg, fail_index_next;
  logic [63:0]      fail_value_reg, fail_value_next;
  logic             wd_expired_reg, wd_expired_next;

  logic             wr_en;
  logic             start;
  logic             full;
  logic [IW:0]      entries;
  chk_entry_t       wr_data;
  chk_entry_t       cur_chk;

  assign wr_data = '{pc: cfg_pc, expected: cfg_expect};

  chk_table #(.NUM_CHK(NUM_CHK)) u_table (
    .CLK     (CLK),
    .resetl  (resetl),
    .clear   (cfg_clear),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_idx  (idx_reg[IW-1:0]),
    .rd_data (cur_chk),
    .entries (entries),
    .full    (full)
  );

  assign cfg_ready        = (state_reg == RC_IDLE) && !full;
  assign wr_en            = cfg_valid && cfg_ready && !cfg_clear;
  assign busy             = (state_reg == RC_RESET_CORE) || (state_reg == RC_RUN) ||
                            (state_reg == RC_SETTLE) || (state_reg == RC_CHECK);
  assign done             = (state_reg == RC_DONE);
  assign all_passed       = done && (pass_count_reg == 8'(entries)) && !wd_expired_reg;
  assign core_resetl      = core_resetl_reg;
  assign core_startpc     = core_startpc_reg;
  assign pass_count       = pass_count_reg;
  assign fail             = fail_reg;
  assign fail_index       = fail_index_reg;
  assign fail_value       = fail_value_reg;
  assign watchdog_expired = wd_expired_reg;

  always_comb begin
    state_next        = state_reg;
    rst_cnt_next      = rst_cnt_reg;
    wd_next           = wd_reg;
    idx_next          = idx_reg;
    core_resetl_next  = core_resetl_reg;
    core_startpc_next = core_startpc_reg;
    pass_count_next   = pass_count_reg;
    fail_next         = fail_reg;
    fail_index_next   = fail_index_reg;
    fail_value_next   = fail_value_reg;
    wd_expired_next   = wd_expired_reg;
    start             = 1'b0;

    if (cfg_clear) begin
      state_next       = RC_IDLE;
      core_resetl_next = 1'b1;
    end else begin
      case (state_reg)
        // An entry written in the same cycle as go counts toward this run.
        RC_IDLE:       start = go && ((entries != '0) || wr_en);
        RC_RESET_CORE: begin
          if (rst_cnt_reg == RST_LAST) begin
            state_next       = RC_RUN;
            core_resetl_next = 1'b1;
          end else begin
            rst_cnt_next = rst_cnt_reg + 1'b1;
          end
        end
        RC_RUN:        if (currentpc >= cur_chk.pc) state_next = RC_SETTLE;
        RC_SETTLE:     state_next = RC_CHECK;
        RC_CHECK: begin
          if (dmemout == cur_chk.expected) begin
            if (pass_count_reg != PASS_SAT) pass_count_next = pass_count_reg + 1'b1;
          end else if (!fail_reg) begin
            fail_next       = 1'b1;
            fail_index_next = idx_reg[IW-1:0];
            fail_value_next = dmemout;
          end
          idx_next   = idx_reg + 1'b1;
          state_next = (idx_next == entries) ? RC_DONE : RC_RUN;
        end
        RC_DONE:       start = go;
        default:       state_next = RC_IDLE;
      endcase

      if (start) begin
        state_next        = RC_RESET_CORE;
        core_startpc_next = startpc;
        core_resetl_next  = 1'b0;
        rst_cnt_next      = '0;
        idx_next          = '0;
        wd_next           = '0;
        pass_count_next   = '0;
        fail_next         = 1'b0;
        fail_index_next   = '0;
        fail_value_next   = '0;
        wd_expired_next   = 1'b0;
      end

      // An expiring watchdog discards whatever the current check would have recorded.
      if (state_reg == RC_RUN || state_reg == RC_SETTLE || state_reg == RC_CHECK) begin
        wd_next = wd_reg + 1'b1;
        if (wd_next == WD_LIMIT && state_next != RC_DONE) begin
          state_next      = RC_DONE;
          wd_expired_next = 1'b1;
          idx_next        = idx_reg;
          pass_count_next = pass_count_reg;
          fail_next       = fail_reg;
          fail_index_next = fail_index_reg;
          fail_value_next = fail_value_reg;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_reg        <= RC_IDLE;
      rst_cnt_reg      <= '0;
      wd_reg           <= '0;
      idx_reg          <= '0;
      core_resetl_reg  <= 1'b1;
      core_startpc_reg <= '0;
      pass_count_reg   <= '0;
      fail_reg         <= 1'b0;
      fail_index_reg   <= '0;
      fail_value_reg   <= '0;
      wd_expired_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rst_cnt_reg      <= rst_cnt_next;
      wd_reg           <= wd_next;
      idx_reg          <= idx_next;
      core_resetl_reg  <= core_resetl_next;
      core_startpc_reg <= core_startpc_next;
      pass_count_reg   <= pass_count_next;
      fail_reg         <= fail_next;
      fail_index_reg   <= fail_index_next;
      fail_value_reg   <= fail_value_next;
      wd_expired_reg   <= wd_expired_next;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with a tiny core model (PC += 4, or stuck).
module tb_run_controller;

  logic        clk = 1'b0;
  logic        resetl;
  logic        cfg_valid, cfg_ready, cfg_clear, go;
  logic [63:0] cfg_pc, cfg_expect, startpc;
  logic        core_resetl;
  logic [63:0] core_startpc, currentpc, dmemout;
  logic        busy, done, all_passed, fail, watchdog_expired;
  logic [7:0]  pass_count;
  logic [1:0]  fail_index;
  logic [63:0] fail_value;

  logic        stuck;
  logic [63:0] dmem_hi;
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] GOOD = 64'h1234_5678_9abc_def0;

  always #5 clk = ~clk;

  run_controller #(.NUM_CHK(4), .CORE_RST_CYCLES(1), .WATCHDOG_MAX(255)) dut (
    .CLK(clk), .resetl(resetl), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pc(cfg_pc), .cfg_expect(cfg_expect), .cfg_clear(cfg_clear), .go(go),
    .startpc(startpc), .core_resetl(core_resetl), .core_startpc(core_startpc),
    .currentpc(currentpc), .dmemout(dmemout), .busy(busy), .done(done),
    .all_passed(all_passed), .pass_count(pass_count), .fail(fail),
    .fail_index(fail_index), .fail_value(fail_value),
    .watchdog_expired(watchdog_expired)
  );

  // Core model: loads startpc while held in reset, otherwise advances by one word.
  always @(posedge clk) begin
    if (!resetl)           currentpc <= 64'h0;
    else if (!core_resetl) currentpc <= core_startpc;
    else if (!stuck)       currentpc <= currentpc + 64'd4;
  end

  // Data memory model: low addresses read 0xF, high addresses read dmem_hi.
  assign dmemout = (currentpc < 64'h58) ? 64'hF : dmem_hi;

  typedef struct {
    logic [63:0] spc;
    logic [63:0] hi;
    logic        stk;
    int          cycles;
    logic [7:0]  pass;
    logic        allp;
    logic        fl;
    logic [1:0]  fidx;
    logic [63:0] fval;
    logic        wd;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [63:0] pc, input logic [63:0] ev);
    cfg_valid  = 1'b1;
    cfg_pc     = pc;
    cfg_expect = ev;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL wait_done: timeout after %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc;
    vecs[0] = '{64'h00, GOOD,       1'b0, 26,  8'd2, 1'b1, 1'b0, 2'd0, 64'h0,    1'b0};
    vecs[1] = '{64'h00, 64'hDEAD,   1'b0, 26,  8'd1, 1'b0, 1'b1, 2'd1, 64'hDEAD, 1'b0};
    vecs[2] = '{64'h10, GOOD,       1'b1, 256, 8'd0, 1'b0, 1'b0, 2'd0, 64'h0,    1'b1};
    vecs[3] = '{64'h40, GOOD,       1'b0, 10,  8'd2, 1'b1, 1'b0, 2'd0, 64'h0,    1'b0};
    vecs[4] = '{64'h60, 64'hDEAD,   1'b0, 7,   8'd0, 1'b0, 1'b1, 2'd0, 64'hDEAD, 1'b0};

    resetl = 1'b0; cfg_valid = 1'b0; cfg_clear = 1'b0; go = 1'b0;
    cfg_pc = '0; cfg_expect = '0; startpc = '0; stuck = 1'b0; dmem_hi = GOOD;
    tick(); tick();
    resetl = 1'b1;

    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_core_resetl", core_resetl, 1);
    chk("rst_core_startpc", core_startpc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass_count", pass_count, 0);
    chk("rst_fail", fail, 0);
    chk("rst_watchdog", watchdog_expired, 0);

    // Fill the table; the fifth offer must be refused.
    for (int i = 0; i < 4; i++) begin
      chk("full_ready_before", cfg_ready, 1);
      cfg_write(64'(8 * (i + 1)), 64'hF);
    end
    chk("full_ready_after4", cfg_ready, 0);
    cfg_write(64'h1000, 64'h77);
    chk("full_ready_after5", cfg_ready, 0);
    startpc = 64'h0; go = 1'b1; tick(); go = 1'b0;
    wait_done(cyc);
    chk("full_pass_count", pass_count, 4);
    chk("full_all_passed", all_passed, 1);

    // Clear empties the table and keeps status; go with no entries is ignored.
    cfg_clear = 1'b1; tick(); cfg_clear = 1'b0;
    chk("clear_done", done, 0);
    chk("clear_ready", cfg_ready, 1);
    chk("clear_pass_kept", pass_count, 4);
    go = 1'b1; tick(); go = 1'b0;
    chk("empty_go_busy", busy, 0);
    chk("empty_go_core_resetl", core_resetl, 1);
    tick();
    chk("empty_go_busy2", busy, 0);

    // Second entry written in the same cycle as go belongs to the run.
    cfg_write(64'h30, 64'hF);
    cfg_valid = 1'b1; cfg_pc = 64'h58; cfg_expect = GOOD;
    startpc = 64'h0; dmem_hi = GOOD; go = 1'b1;
    tick();
    cfg_valid = 1'b0; go = 1'b0;
    wait_done(cyc);
    chk("samecycle_pass_count", pass_count, 2);
    chk("samecycle_all_passed", all_passed, 1);

    for (int v = 0; v < 5; v++) begin
      startpc = vecs[v].spc; dmem_hi = vecs[v].hi; stuck = vecs[v].stk;
      go = 1'b1; tick(); go = 1'b0;
      chk("go_core_resetl_low", core_resetl, 0);
      chk("go_core_startpc", core_startpc, vecs[v].spc);
      chk("go_busy", busy, 1);
      cyc = 0;
      while (!done && cyc < 400) begin
        tick();
        cyc++;
        if (cyc == 1) chk("go_core_resetl_high", core_resetl, 1);
      end
      $display("vec %0d: startpc=%h cycles=%0d pass=%0d fail=%0d idx=%0d val=%h wd=%0d",
               v, vecs[v].spc, cyc, pass_count, fail, fail_index, fail_value, watchdog_expired);
      chk("vec_done", done, 1);
      chk("vec_cycles", 64'(cyc), 64'(vecs[v].cycles));
      chk("vec_busy", busy, 0);
      chk("vec_pass_count", pass_count, vecs[v].pass);
      chk("vec_all_passed", all_passed, vecs[v].allp);
      chk("vec_fail", fail, vecs[v].fl);
      chk("vec_fail_index", fail_index, vecs[v].fidx);
      chk("vec_fail_value", fail_value, vecs[v].fval);
      chk("vec_watchdog", watchdog_expired, vecs[v].wd);
    end

    // Reset in the middle of a run.
    stuck = 1'b1; startpc = 64'h10; go = 1'b1; tick(); go = 1'b0;
    tick(); tick(); tick();
    chk("midrun_busy", busy, 1);
    resetl = 1'b0; tick(); resetl = 1'b1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_core_resetl", core_resetl, 1);
    chk("midrun_rst_core_startpc", core_startpc, 0);
    chk("midrun_rst_cfg_ready", cfg_ready, 1);
    chk("midrun_rst_pass", pass_count, 0);
    chk("midrun_rst_fail_value", fail_value, 0);
    chk("midrun_rst_watchdog", watchdog_expired, 0);
    go = 1'b1; tick(); go = 1'b0;
    chk("midrun_rst_entries0", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
